// File: rtl/ascii_line_buffer.sv
// ascii_line_buffer: collects typed characters into an edit line, exposes the
// newest WIN characters for display, and drains a committed line over a
// valid/ready port.
module ascii_line_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIN   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [7:0]                 ascii_data,
    input  logic                       ascii_data_stb,
    output logic [7:0]                 rd_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [8*WIN-1:0]           disp_word,
    output logic                       ovf_stb,
    output logic                       busy_stb,
    output logic                       line_done_stb
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned DW = 8 * WIN;

    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_CR = 8'h0D;

    typedef enum logic {
        EDIT  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rd_valid_q, rd_valid_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic [DW-1:0] disp_q, disp_d;
    logic          ovf_q, ovf_d;
    logic          busy_q, busy_d;

    logic [7:0]    mem_q [DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_wa;
    logic [7:0]    mem_wd;

    logic          last_c;
    logic [AW-1:0] top_idx_c;

    // Final character of the committed line is at the read pointer.
    assign last_c    = (CW'(rd_ptr_q) == (count_q - CW'(1)));
    // Character that scrolls back into the oldest display slot on backspace.
    assign top_idx_c = AW'(count_q - CW'(WIN + 1));

    // Next-state, datapath and strobe logic.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;
        disp_d     = disp_q;
        ovf_d      = 1'b0;
        busy_d     = 1'b0;
        mem_we     = 1'b0;
        mem_wa     = AW'(count_q);
        mem_wd     = ascii_data;

        case (state_q)
            EDIT: begin
                if (ascii_data_stb) begin
                    if (ascii_data == CODE_BS) begin
                        if (count_q != '0) begin
                            count_d = count_q - CW'(1);
                            disp_d  = disp_q >> 8;
                            if (count_q > CW'(WIN)) begin
                                disp_d = disp_d | (DW'(mem_q[top_idx_c]) << (DW - 8));
                            end
                        end
                    end else if (ascii_data == CODE_CR) begin
                        if (count_q != '0) begin
                            state_d    = DRAIN;
                            rd_ptr_d   = '0;
                            rd_valid_d = 1'b1;
                            rd_data_d  = mem_q[AW'(0)];
                        end
                    end else if (count_q < CW'(DEPTH)) begin
                        mem_we  = 1'b1;
                        count_d = count_q + CW'(1);
                        disp_d  = (disp_q << 8) | DW'(ascii_data);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (ascii_data_stb) begin
                    busy_d = 1'b1;
                end
                if (rd_ready) begin
                    if (last_c) begin
                        state_d    = EDIT;
                        count_d    = '0;
                        rd_ptr_d   = '0;
                        rd_valid_d = 1'b0;
                        disp_d     = '0;
                    end else begin
                        rd_ptr_d  = rd_ptr_q + AW'(1);
                        rd_data_d = mem_q[rd_ptr_q + AW'(1)];
                    end
                end
            end
            default: begin
                state_d = EDIT;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EDIT;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            disp_q     <= disp_d;
            ovf_q      <= ovf_d;
            busy_q     <= busy_d;
        end
    end

    // Line storage; contents survive reset since count bounds what is visible.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    assign rd_data       = rd_data_q;
    assign rd_valid      = rd_valid_q;
    assign count         = count_q;
    assign disp_word     = disp_q;
    assign ovf_stb       = ovf_q;
    assign busy_stb      = busy_q;
    assign line_done_stb = rd_valid_q & rd_ready & last_c;

endmodule

// File: tb/tb_ascii_line_buffer.sv
// Bench for ascii_line_buffer: directed typing/commit sequences; a scoreboard
// queue holds expected drained characters and a monitor checks each transfer.
module tb_ascii_line_buffer;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned WIN   = 2;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      ascii_data = 8'h00;
    logic            ascii_data_stb = 1'b0;
    logic [7:0]      rd_data;
    logic            rd_valid;
    logic            rd_ready = 1'b0;
    logic [CW-1:0]   count;
    logic [8*WIN-1:0] disp_word;
    logic            ovf_stb;
    logic            busy_stb;
    logic            line_done_stb;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;

    exp_t exp_q[$];

    int tests = 0;
    int fails = 0;
    int ovf_seen = 0;
    int busy_seen = 0;
    int done_seen = 0;
    int ovf_exp = 0;
    int busy_exp = 0;
    int done_exp = 0;

    ascii_line_buffer #(.DEPTH(DEPTH), .WIN(WIN)) dut (
        .clk           (clk),
        .rst           (rst),
        .ascii_data    (ascii_data),
        .ascii_data_stb(ascii_data_stb),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .count         (count),
        .disp_word     (disp_word),
        .ovf_stb       (ovf_stb),
        .busy_stb      (busy_stb),
        .line_done_stb (line_done_stb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every transfer must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (ovf_stb)       ovf_seen++;
            if (busy_stb)      busy_seen++;
            if (line_done_stb) done_seen++;
            if (rd_valid && rd_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_transfer", {24'h0, rd_data}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rd_data", {24'h0, rd_data}, {24'h0, e.data});
                    chk("line_done", {31'h0, line_done_stb}, {31'h0, e.last});
                end
            end
        end
    end

    // One-cycle strobe, called and returning at posedge+1.
    task automatic send(input logic [7:0] code);
        ascii_data     = code;
        ascii_data_stb = 1'b1;
        @(posedge clk);
        #1;
        ascii_data_stb = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for the line to finish draining.
    task automatic wait_idle(input string name);
        for (int i = 0; i < 20; i++) begin
            if (!rd_valid) break;
            cycle();
        end
        chk(name, {31'h0, rd_valid}, 32'h0);
    endtask

    task automatic chk_state(input string name, input int c, input logic [15:0] d);
        chk({name, "_count"}, 32'(count), 32'(c));
        chk({name, "_disp"}, {16'h0, disp_word}, {16'h0, d});
    endtask

    initial begin
        // Reset
        #23;
        chk("rst_valid", {31'h0, rd_valid}, 32'h0);
        chk_state("rst", 0, 16'h0000);
        chk("rst_strobes", {29'h0, ovf_stb, busy_stb, line_done_stb}, 32'h0);
        rst = 1'b0;
        cycle();

        // Typing and backspace exposing the older character
        send(8'h41); send(8'h42);
        chk_state("ab", 2, 16'h4142);
        send(8'h43);
        chk_state("abc", 3, 16'h4243);
        send(8'h08);
        chk_state("bs", 2, 16'h4142);
        send(8'h08);
        chk_state("bs2", 1, 16'h0041);
        send(8'h08);
        chk_state("bs3", 0, 16'h0000);

        // Control codes on an empty line, rd_ready without rd_valid
        rd_ready = 1'b1;
        send(8'h08);
        send(8'h0D);
        cycle();
        chk("empty_valid", {31'h0, rd_valid}, 32'h0);
        chk_state("empty", 0, 16'h0000);
        chk("empty_pulses", 32'(ovf_seen + busy_seen + done_seen), 32'h0);

        // Commit "12" with rd_ready high; strobe on the final transfer
        send(8'h31); send(8'h32);
        exp_q.push_back('{data: 8'h31, last: 1'b0});
        exp_q.push_back('{data: 8'h32, last: 1'b1});
        done_exp++;
        send(8'h0D);
        chk("commit_valid", {31'h0, rd_valid}, 32'h1);
        chk_state("drain_hold", 2, 16'h3132);
        cycle();
        send(8'h55);
        busy_exp++;
        chk("after_drain_valid", {31'h0, rd_valid}, 32'h0);
        chk_state("after_drain", 0, 16'h0000);
        wait_idle("drain12_done");
        rd_ready = 1'b0;

        // Overflow at DEPTH
        for (int i = 0; i < 17; i++) send(8'h58);
        ovf_exp++;
        cycle();
        chk_state("full", 16, 16'h5858);
        chk("ovf_once", 32'(ovf_seen), 32'(ovf_exp));
        send(8'h08);
        chk("full_bs_count", 32'(count), 32'd15);
        for (int i = 0; i < 15; i++) send(8'h08);
        chk_state("cleared", 0, 16'h0000);

        // Commit "AB" with backpressure and a busy strobe
        send(8'h41); send(8'h42);
        exp_q.push_back('{data: 8'h41, last: 1'b0});
        exp_q.push_back('{data: 8'h42, last: 1'b1});
        done_exp++;
        send(8'h0D);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                send(8'h43);
                busy_exp++;
            end else begin
                cycle();
            end
            chk("stall_data", {24'h0, rd_data}, 32'h41);
            chk("stall_valid", {31'h0, rd_valid}, 32'h1);
        end
        chk_state("stall", 2, 16'h4142);
        rd_ready = 1'b1;
        cycle();
        wait_idle("drainab_done");
        chk("busy_count", 32'(busy_seen), 32'(busy_exp));
        chk_state("ab_done", 0, 16'h0000);
        rd_ready = 1'b0;

        // Reset in the middle of draining "XYZ"
        send(8'h58); send(8'h59); send(8'h5A);
        exp_q.push_back('{data: 8'h58, last: 1'b0});
        send(8'h0D);
        rd_ready = 1'b1;
        cycle();
        rd_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", {31'h0, rd_valid}, 32'h0);
        chk_state("midrst", 0, 16'h0000);
        chk("midrst_done", 32'(done_seen), 32'(done_exp));
        ascii_data = 8'h51;
        ascii_data_stb = 1'b1;
        @(posedge clk);
        #2;
        ascii_data_stb = 1'b0;
        rst = 1'b0;
        cycle();
        chk_state("post_rst", 0, 16'h0000);

        // New line "Q" after reset
        send(8'h51);
        exp_q.push_back('{data: 8'h51, last: 1'b1});
        done_exp++;
        rd_ready = 1'b1;
        send(8'h0D);
        chk("q_valid", {31'h0, rd_valid}, 32'h1);
        cycle();
        wait_idle("drainq_done");
        rd_ready = 1'b0;
        cycle();

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        chk("done_total", 32'(done_seen), 32'(done_exp));
        chk("ovf_total", 32'(ovf_seen), 32'(ovf_exp));
        chk("busy_total", 32'(busy_seen), 32'(busy_exp));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ascii_line_buffer.md
ASCII_LINE_BUFFER -- requirements
Module: ascii_line_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 16, edit-buffer capacity in characters; power of two, 2..256.
REQ-002 SHALL provide parameter WIN, default 2, number of characters in the display window; 1..DEPTH.
REQ-003 SHALL provide port clk, input, 1, sole clock; all state changes on rising edge.
REQ-004 SHALL provide port rst, input, 1, reset, asynchronous and active-high.
REQ-005 SHALL provide port ascii_data, input, 8, character code from the keycode converter.
REQ-006 SHALL provide port ascii_data_stb, input, 1, one-cycle strobe qualifying ascii_data; back-to-back strobes legal.
REQ-007 SHALL provide port rd_data, output, 8, committed-line character at the current read position.
REQ-008 SHALL provide port rd_valid, output, 1, rd_data valid.
REQ-009 SHALL provide port rd_ready, input, 1, consumer accepts rd_data; transfer = rd_valid & rd_ready.
REQ-010 SHALL provide port count, output, $clog2(DEPTH+1), characters held in the current line.
REQ-011 SHALL provide port disp_word, output, 8*WIN, newest WIN characters of the line, newest in [7:0], older in successively higher bytes, absent positions 0x00; sized for direct connection to the 7-segment converter when WIN=2.
REQ-012 SHALL provide port ovf_stb, output, 1, one-cycle pulse: character dropped because the edit buffer was full.
REQ-013 SHALL provide port busy_stb, output, 1, one-cycle pulse: strobe dropped because a committed line was draining.
REQ-014 SHALL provide port line_done_stb, output, 1, one-cycle pulse on the final transfer of a committed line.

Function
REQ-015 SHALL implement a two-state FSM: EDIT (accept input) and DRAIN (output a committed line).
REQ-016 In EDIT, a strobe with code other than 0x08/0x0D and count<DEPTH SHALL write the code at index count and increment count; count and disp_word update in the following cycle.
REQ-017 In EDIT, a strobe with such a code and count==DEPTH SHALL leave the buffer unchanged and assert ovf_stb in the following cycle.
REQ-018 In EDIT, code 0x08 (backspace) SHALL decrement count if count>0; at count==0 it SHALL be ignored with no pulse.
REQ-019 In EDIT, code 0x0D (enter) with count>0 SHALL move the FSM to DRAIN with read pointer 0; rd_valid SHALL be high the following cycle; enter with count==0 SHALL be ignored.
REQ-020 Codes 0x08 and 0x0D SHALL never be stored.
REQ-021 rd_valid SHALL be high exactly while in DRAIN; rd_data SHALL equal the buffer at the read pointer, stable while rd_valid & !rd_ready.
REQ-022 Each transfer SHALL advance the read pointer by one; rd_ready with rd_valid low SHALL have no effect.
REQ-023 The transfer at read pointer count-1 SHALL assert line_done_stb in the same cycle, and next cycle SHALL return to EDIT with count=0, rd_valid=0, disp_word=0.
REQ-024 In DRAIN, every strobe (any code) SHALL be discarded and busy_stb asserted in the following cycle, including a strobe coinciding with the final transfer.
REQ-025 During DRAIN, count and disp_word SHALL hold their values from the commit.
REQ-026 disp_word SHALL be registered and reflect count and buffer contents after every edit (backspace exposes the previous character again).
REQ-027 ovf_stb, busy_stb and line_done_stb SHALL be high for exactly one cycle per event, never merged or stretched.

Reset
REQ-028 Asserting rst SHALL immediately force EDIT, count=0, read pointer 0, rd_valid=0, disp_word=0, all strobes 0, independent of clk.
REQ-029 rst asserted mid-DRAIN SHALL abandon the line with no line_done_stb; buffer contents need not be cleared.
REQ-030 Strobes while rst is high SHALL be ignored; normal operation SHALL resume on the first rising clk edge after deassertion.

Verification
REQ-031 Type 0x41,0x42,0x43 (WIN=2) -> count=3, disp_word=0x4243; send 0x08 -> count=2, disp_word=0x4142.
REQ-032 Type 0x31,0x32 then 0x0D, rd_ready held high -> rd_data 0x31 then 0x32 on consecutive cycles, line_done_stb with 0x32, then count=0, disp_word=0x0000, rd_valid=0.
REQ-033 DEPTH=16: send 17 x 0x58 -> count=16, exactly one ovf_stb; then 0x08 -> count=15.
REQ-034 Commit line "AB", hold rd_ready low 5 cycles, strobe 0x43 during DRAIN -> rd_data stays 0x41, busy_stb once, drained line is exactly 0x41,0x42.
REQ-035 0x08 and 0x0D at count=0 -> no state change, no pulses, rd_valid stays 0.
REQ-036 Commit "XYZ", assert rst after first transfer -> immediate rd_valid=0, count=0, no line_done_stb; new line "Q" then commits and drains normally.
